// File: rtl/regfile_scb.sv
// regfile_scb: multi-port register file with per-entry pending scoreboard; REGFILE_SCB_BYPASS_EN adds write-to-read forwarding
module regfile_scb #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2,
   parameter int NW = 2
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             ready,
   input  logic [NR*AW-1:0] ra,
   output logic [NR*DW-1:0] rd,
   output logic [NR-1:0]    rbusy,
   input  logic [NW-1:0]    we,
   input  logic [NW*AW-1:0] wa,
   input  logic [NW*DW-1:0] wd,
   input  logic             iss_v,
   input  logic [AW-1:0]    iss_a
);
   typedef enum logic {INIT, RUN} state_t;
   state_t           state_q;
   logic [AW-1:0]    cnt_q;
   logic             ready_q;
   logic [DW-1:0]    mem_q [2**AW];
   logic [2**AW-1:0] pend_q;
   assign ready = ready_q;
   // init sweep clears one entry per cycle; in RUN later write ports override earlier ones, then issue overrides the pending clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else if (state_q == INIT) begin
         mem_q[cnt_q]  <= '0;
         pend_q[cnt_q] <= 1'b0;
         cnt_q         <= cnt_q + AW'(1);
         if (&cnt_q) begin
            state_q <= RUN;
            ready_q <= 1'b1;
         end
      end else begin
         for (int j = 0; j < NW; j++)
            if (we[j] && wa[j*AW +: AW] != '0) begin
               mem_q[wa[j*AW +: AW]]  <= wd[j*DW +: DW];
               pend_q[wa[j*AW +: AW]] <= 1'b0;
            end
         if (iss_v && iss_a != '0) pend_q[iss_a] <= 1'b1;
      end
   end
   // combinational read ports, forced to zero until initialisation completes
   always_comb begin
      rd    = '0;
      rbusy = '0;
      if (state_q == RUN)
         for (int i = 0; i < NR; i++) begin
            rd[i*DW +: DW] = mem_q[ra[i*AW +: AW]];
            rbusy[i]       = pend_q[ra[i*AW +: AW]];
`ifdef REGFILE_SCB_BYPASS_EN
            for (int j = 0; j < NW; j++)
               if (we[j] && wa[j*AW +: AW] == ra[i*AW +: AW] && ra[i*AW +: AW] != '0) begin
                  rd[i*DW +: DW] = wd[j*DW +: DW];
                  rbusy[i]       = iss_v && iss_a == ra[i*AW +: AW];
               end
`endif
         end
   end
endmodule

// File: doc/regfile_scb.md
REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DW  32  data width
  AW  5  address width; depth 2**AW
  NR  2  read-port count
  NW  2  write-port count
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  sole clock; all state changes on its rising edge
  resetn  in  1  reset, synchronous, active-low
  ready  out  1  initialisation complete
  ra  in  NR*AW  read addresses; port i uses bits [i*AW +: AW]
  rd  out  NR*DW  read data, combinational
  rbusy  out  NR  pending flag of each read address
  we  in  NW  write enables
  wa  in  NW*AW  write addresses
  wd  in  NW*DW  write data
  iss_v  in  1  producer-issue strobe
  iss_a  in  AW  register to mark pending on issue

Function
REQ-003 The block SHALL have a two-state FSM, INIT and RUN; a per-entry pending bit; and an AW-bit init counter.
REQ-004 INIT SHALL zero entry[cnt] and clear pending[cnt] each cycle, then increment cnt.
REQ-005 INIT SHALL move to RUN on the edge where cnt == 2**AW-1, after which ready=1; ready SHALL go high exactly 2**AW cycles after the first edge with resetn=1.
REQ-006 During INIT, rd and rbusy SHALL be 0 on all ports, and we and iss_v SHALL be ignored.
REQ-007 Address 0 SHALL always read 0, ignore writes, and never be pending; iss_a=0 SHALL be a no-op.
REQ-008 In RUN, reads SHALL be combinational: rd[i] = entry[ra[i]], rbusy[i] = pending[ra[i]].
REQ-009 In RUN, writes SHALL be synchronous: when we[j]=1 and wa[j]!=0, entry[wa[j]] SHALL take wd[j] and pending[wa[j]] SHALL clear at the edge.
REQ-010 When several write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-011 iss_v=1 SHALL set pending[iss_a] at the edge.
REQ-012 When an issue and a write target the same address in the same cycle, the data SHALL be written and pending SHALL end set (issue wins).
REQ-013 Read ports SHALL be independent; any number of them may read the same address.

Reset
REQ-014 resetn=0 at any edge, in any state including mid-INIT, SHALL force state=INIT, cnt=0 and ready=0 from the next cycle.
REQ-015 Output values in reset/INIT SHALL be ready=0, rd=0 and rbusy=0.
REQ-016 Entry contents SHALL be defined only after INIT completes.

Configuration
REQ-017 Macro REGFILE_SCB_BYPASS_EN, when defined, SHALL enable same-cycle write-to-read forwarding in RUN:
  - if any we[j]=1 with wa[j]==ra[i]!=0, rd[i] SHALL equal wd of the highest such j
  - rbusy[i] SHALL be 0 in that case, unless iss_v=1 with iss_a==ra[i]
REQ-018 Without REGFILE_SCB_BYPASS_EN, rd and rbusy SHALL reflect stored state only; write data becomes visible the cycle after the edge.

Verification
REQ-019 Release resetn, defaults -> ready=0 for cycles 0..31, ready=1 at cycle 32; every address then reads 0 with rbusy=0.
REQ-020 RUN; we[0]=1, wa=3, wd=0xDEADBEEF; ra[1]=3 same cycle -> rd[1]=0xDEADBEEF with BYPASS_EN, old value without; next cycle 0xDEADBEEF in both builds.
REQ-021 we[0] and we[1] both write addr 7, wd 0x11 and 0x22 -> addr 7 reads 0x22.
REQ-022 iss_v=1, iss_a=9 -> rbusy=1 for ra=9 next cycle; later write addr 9 with simultaneous iss_a=9 -> data updated, rbusy stays 1; write addr 9 alone -> rbusy=0.
REQ-023 Write 0x5 to addr 0 and iss_a=0 -> addr 0 reads 0 with rbusy=0.
REQ-024 Assert resetn=0 for one cycle at init cycle 10, then release -> ready rises 32 cycles after release; a value written before the reset reads 0 afterwards.
